// File: rtl/pwr_activity_counter_pkg.sv
// Shared types and arithmetic helpers for the activity-counter power probe.
// Counter widths up to MAX_W bits and channel counts up to MAX_NCH are supported.
package pwr_pkg;

    localparam int MAX_W   = 32;
    localparam int MAX_NCH = 64;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_CAPT = 1'b1
    } rd_state_t;

    // Unsigned add that clamps at 2^w-1; operands are zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] sat_add(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      w
    );
        logic [MAX_W:0] sum;
        logic [MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ({{MAX_W{1'b0}}, 1'b1} << w) - {{MAX_W{1'b0}}, 1'b1};
        return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
    endfunction

    function automatic logic [MAX_W-1:0] popcount(input logic [MAX_NCH-1:0] v);
        logic [MAX_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_NCH; i++) begin
            n = n + {{(MAX_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pwr_activity_counter_if.sv
// Activity/control inputs and read-port outputs of the power activity counter.
// master drives activity and read requests; slave is the counter.
interface pwr_activity_if #(
    parameter int NCH   = 8,
    parameter int TOT_W = 20
);
    localparam int SEL_W = $clog2(NCH) + 1;

    logic [NCH-1:0]   act_in;
    logic             cnt_en;
    logic             clr;
    logic             rd_req;
    logic [SEL_W-1:0] rd_sel;
    logic [TOT_W-1:0] rd_data;
    logic             rd_valid;
    logic [NCH-1:0]   sat;
    logic             busy;

    modport master (
        output act_in, cnt_en, clr, rd_req, rd_sel,
        input  rd_data, rd_valid, sat, busy
    );

    modport slave (
        input  act_in, cnt_en, clr, rd_req, rd_sel,
        output rd_data, rd_valid, sat, busy
    );

endinterface

// File: rtl/pwr_activity_counter_chan_cnt.sv
// One monitored channel: edge detector, saturating transition counter, sticky sat flag.
// The raw edge strobe is exported so the top can accumulate the all-channel total.
module pwr_chan_cnt
    import pwr_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int EDGE_MODE = 0
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             i_act,
    input  logic             i_cnt_en,
    input  logic             i_clr,
    output logic             o_ev,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_act_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             w_ev;
    logic [MAX_W-1:0] w_sum;
    logic [MAX_W-1:0] w_unused_sum;

    always_comb begin
        w_ev  = (EDGE_MODE == 0) ? (i_act & ~r_act_q) : (i_act ^ r_act_q);
        w_sum = sat_add(MAX_W'(r_cnt), MAX_W'(w_ev), CNT_W);
    end

    assign w_unused_sum = w_sum;

    // act_q tracks the input unconditionally so enabling mid-stream sees no stale edge.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_act_q <= 1'b0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_act_q <= i_act;
            if (i_clr) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (i_cnt_en) begin
                r_cnt <= w_sum[CNT_W-1:0];
                if (w_sum[CNT_W-1:0] == CNT_MAX) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign o_ev  = w_ev;
    assign o_cnt = r_cnt;
    assign o_sat = r_sat;

endmodule

// File: rtl/pwr_activity_counter.sv
// Power-estimation probe: per-channel transition counters, saturating total, registered read port.
//  state   | meaning
//  RD_IDLE | no read in flight; rd_req captures the selected value
//  RD_CAPT | captured value moves to rd_data, rd_valid pulses next cycle
module pwr_activity_counter
    import pwr_pkg::*;
#(
    parameter int NCH       = 8,
    parameter int CNT_W     = 16,
    parameter int TOT_W     = 20,
    parameter int EDGE_MODE = 0
) (
    input  logic           clk,
    input  logic           reset_L,
    pwr_activity_if.slave  bus
);

    localparam int SEL_W = $clog2(NCH) + 1;

    logic [NCH-1:0]     w_ev;
    logic [NCH-1:0]     w_sat;
    logic [CNT_W-1:0]   w_cnt [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        pwr_chan_cnt #(
            .CNT_W     (CNT_W),
            .EDGE_MODE (EDGE_MODE)
        ) u_chan (
            .clk      (clk),
            .reset_L  (reset_L),
            .i_act    (bus.act_in[g]),
            .i_cnt_en (bus.cnt_en),
            .i_clr    (bus.clr),
            .o_ev     (w_ev[g]),
            .o_cnt    (w_cnt[g]),
            .o_sat    (w_sat[g])
        );
    end

    logic [TOT_W-1:0]   r_tot;
    logic [MAX_NCH-1:0] w_ev_ext;
    logic [MAX_W-1:0]   w_tot_sum;
    logic [MAX_W-1:0]   w_unused_tot;

    always_comb begin
        w_ev_ext          = '0;
        w_ev_ext[NCH-1:0] = w_ev;
        w_tot_sum         = sat_add(MAX_W'(r_tot), popcount(w_ev_ext), TOT_W);
    end

    assign w_unused_tot = w_tot_sum;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_tot <= '0;
        end else if (bus.clr) begin
            r_tot <= '0;
        end else if (bus.cnt_en) begin
            r_tot <= w_tot_sum[TOT_W-1:0];
        end
    end

    // Out-of-range selects fall through to zero.
    logic [TOT_W-1:0] w_sel_val;

    always_comb begin
        w_sel_val = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                w_sel_val = TOT_W'(w_cnt[i]);
            end
        end
        if (bus.rd_sel == SEL_W'(NCH)) begin
            w_sel_val = r_tot;
        end
    end

    rd_state_t        r_state;
    rd_state_t        w_state_nxt;
    logic             w_capt_en;
    logic [TOT_W-1:0] r_cap;
    logic [TOT_W-1:0] r_rd_data;
    logic             r_rd_valid;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capt_en   = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (bus.rd_req) begin
                    w_state_nxt = RD_CAPT;
                    w_capt_en   = 1'b1;
                end
            end
            RD_CAPT: w_state_nxt = RD_IDLE;
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    // Snapshot is taken before the request cycle's events land, so later clr cannot disturb it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cap      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_capt_en) begin
                r_cap <= w_sel_val;
            end
            if (r_state == RD_CAPT) begin
                r_rd_data <= r_cap;
            end
            r_rd_valid <= (r_state == RD_CAPT);
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.sat      = w_sat;
    assign bus.busy     = (r_state == RD_CAPT);

endmodule

// File: tb/tb_pwr_activity_counter.sv
// Scoreboard bench: three counter variants (rise-only, both-edge, 4-bit counters) share one stimulus
// stream; a transition-counting reference model predicts reads, sat flags and busy/valid timing.
module tb_pwr_activity_counter;

    localparam int NCH     = 8;
    localparam int TOT_W   = 20;
    localparam int NI      = 3;
    localparam int TOT_MAX = (1 << TOT_W) - 1;

    logic clk     = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] t_act = '0;
    logic       t_en  = 1'b0;
    logic       t_clr = 1'b0;
    logic       t_req = 1'b0;
    logic [3:0] t_sel = '0;

    pwr_activity_if #(.NCH(NCH), .TOT_W(TOT_W)) bus0 ();
    pwr_activity_if #(.NCH(NCH), .TOT_W(TOT_W)) bus1 ();
    pwr_activity_if #(.NCH(NCH), .TOT_W(TOT_W)) bus2 ();

    assign bus0.act_in = t_act;  assign bus1.act_in = t_act;  assign bus2.act_in = t_act;
    assign bus0.cnt_en = t_en;   assign bus1.cnt_en = t_en;   assign bus2.cnt_en = t_en;
    assign bus0.clr    = t_clr;  assign bus1.clr    = t_clr;  assign bus2.clr    = t_clr;
    assign bus0.rd_req = t_req;  assign bus1.rd_req = t_req;  assign bus2.rd_req = t_req;
    assign bus0.rd_sel = t_sel;  assign bus1.rd_sel = t_sel;  assign bus2.rd_sel = t_sel;

    logic [TOT_W-1:0] o_data  [NI];
    logic             o_valid [NI];
    logic [NCH-1:0]   o_sat   [NI];
    logic             o_busy  [NI];

    assign o_data[0] = bus0.rd_data;  assign o_valid[0] = bus0.rd_valid;
    assign o_sat[0]  = bus0.sat;      assign o_busy[0]  = bus0.busy;
    assign o_data[1] = bus1.rd_data;  assign o_valid[1] = bus1.rd_valid;
    assign o_sat[1]  = bus1.sat;      assign o_busy[1]  = bus1.busy;
    assign o_data[2] = bus2.rd_data;  assign o_valid[2] = bus2.rd_valid;
    assign o_sat[2]  = bus2.sat;      assign o_busy[2]  = bus2.busy;

    pwr_activity_counter #(.NCH(NCH), .CNT_W(16), .TOT_W(TOT_W), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset_L(reset_L), .bus(bus0.slave));
    pwr_activity_counter #(.NCH(NCH), .CNT_W(16), .TOT_W(TOT_W), .EDGE_MODE(1)) dut1 (
        .clk(clk), .reset_L(reset_L), .bus(bus1.slave));
    pwr_activity_counter #(.NCH(NCH), .CNT_W(4),  .TOT_W(TOT_W), .EDGE_MODE(0)) dut2 (
        .clk(clk), .reset_L(reset_L), .bus(bus2.slave));

    // Reference model: values are what the DUT should show after the next rising edge.
    int         cnt_max   [NI] = '{65535, 65535, 15};
    int         edge_both [NI] = '{0, 1, 0};
    int         m_cnt [NI][NCH];
    int         m_tot [NI];
    logic [7:0] m_sat [NI];
    logic [7:0] m_prev;
    logic       e_busy;
    logic       e_valid;
    int         exp_q [NI][$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int k, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_tot[k] = 0;
            m_sat[k] = '0;
            for (int i = 0; i < NCH; i++) m_cnt[k][i] = 0;
            exp_q[k].delete();
        end
        m_prev  = '0;
        e_busy  = 1'b0;
        e_valid = 1'b0;
    endtask

    task automatic step();
        int ev;
        int nev;
        for (int k = 0; k < NI; k++) begin
            if (t_req && !e_busy) begin
                if (t_sel < NCH)       exp_q[k].push_back(m_cnt[k][t_sel]);
                else if (t_sel == NCH) exp_q[k].push_back(m_tot[k]);
                else                   exp_q[k].push_back(0);
            end
            if (t_clr) begin
                m_tot[k] = 0;
                m_sat[k] = '0;
                for (int i = 0; i < NCH; i++) m_cnt[k][i] = 0;
            end else if (t_en) begin
                nev = 0;
                for (int i = 0; i < NCH; i++) begin
                    ev = ((t_act[i] && !m_prev[i]) ||
                          (edge_both[k] != 0 && !t_act[i] && m_prev[i])) ? 1 : 0;
                    nev += ev;
                    m_cnt[k][i] = (m_cnt[k][i] + ev > cnt_max[k]) ? cnt_max[k] : m_cnt[k][i] + ev;
                    if (m_cnt[k][i] == cnt_max[k]) m_sat[k][i] = 1'b1;
                end
                m_tot[k] = (m_tot[k] + nev > TOT_MAX) ? TOT_MAX : m_tot[k] + nev;
            end
        end
        e_valid = e_busy;
        e_busy  = t_req && !e_busy;
        m_prev  = t_act;
    endtask

    task automatic cyc(input int a, input int en, input int c, input int rq, input int s);
        @(negedge clk);
        #1;
        t_act = 8'(a);
        t_en  = (en != 0);
        t_clr = (c != 0);
        t_req = (rq != 0);
        t_sel = 4'(s);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
    endtask

    // Reset lands between edges; any read in flight must vanish with it.
    task automatic rst_pulse();
        @(negedge clk);
        #1;
        reset_L = 1'b0;
        t_act = '0; t_en = 1'b1; t_clr = 1'b0; t_req = 1'b0; t_sel = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_L = 1'b1;
        step();
    endtask

    initial begin : monitor
        int e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                check("busy", k, o_busy[k], e_busy);
                check("rd_valid", k, o_valid[k], e_valid);
                check("sat", k, o_sat[k], m_sat[k]);
                if (o_valid[k]) begin
                    if (exp_q[k].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rd_unexpected dut%0d: got rd_valid with data %0d, expected no read (t=%0t)",
                                 k, o_data[k], $time);
                    end else begin
                        e = exp_q[k].pop_front();
                        check("rd_data", k, o_data[k], e);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        model_reset();
        reset_L = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset_L = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            cyc(8'h08, 1, 0, 0, 0);
            cyc(8'h00, 1, 0, 0, 0);
        end
        cyc(0, 1, 0, 1, 3);
        idle(2);
        cyc(0, 1, 0, 1, 8);
        cyc(0, 1, 0, 1, 9);
        idle(1);
        cyc(0, 1, 0, 1, 9);
        idle(2);

        cyc(8'hFF, 1, 0, 0, 0);
        cyc(8'hFF, 1, 0, 1, 8);
        idle(3);

        for (int i = 0; i < 3; i++) begin
            cyc(8'h0F, 0, 0, 0, 0);
            cyc(8'h00, 0, 0, 0, 0);
        end
        cyc(0, 1, 0, 1, 1);
        idle(2);

        for (int i = 0; i < 20; i++) begin
            cyc(8'h01, 1, 0, 0, 0);
            cyc(8'h00, 1, 0, 0, 0);
        end
        cyc(0, 1, 0, 1, 0);
        idle(2);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 1, 0);
        idle(2);

        cyc(8'h02, 1, 0, 0, 0);
        cyc(8'h00, 1, 0, 1, 1);
        cyc(8'h02, 1, 1, 0, 0);
        idle(2);

        cyc(8'h10, 1, 0, 0, 0);
        cyc(8'h30, 1, 0, 1, 4);
        rst_pulse();
        cyc(0, 1, 0, 1, 3);
        idle(2);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_pulse();
            end else begin
                cyc(int'($urandom_range(0, 255)),
                    ($urandom_range(0, 9) != 0) ? 1 : 0,
                    ($urandom_range(0, 39) == 0) ? 1 : 0,
                    ($urandom_range(0, 3) == 0) ? 1 : 0,
                    int'($urandom_range(0, 9)));
            end
        end
        idle(4);

        @(negedge clk);
        #2;
        for (int k = 0; k < NI; k++) begin
            check("reads_outstanding", k, exp_q[k].size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
